vga_timing_gen: RTL

- Generates the pixel coordinates, the visible-area flag and the sync signals that every sprite/palette renderer in the display path consumes.
- Runs on the pixel clock. It drives DrawX/DrawY/blank into the renderers.
- It drives hs/vs to the VGA connector, delayed so they line up with the renderers' registered RGB.
- It also provides frame and vblank strobes, so game logic can update sprite positions between frames.

---
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA pixel/line timing: registered DrawX/DrawY/blank and strobes, plus hs/vs
// delayed through a short pipeline to line up with the renderers' registered RGB.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SYNC_END = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SYNC_END = V_ACTIVE + V_FRONT + V_SYNC;

  typedef enum logic [1:0] {PhActive, PhFront, PhSync, PhBack} phase_e;

  logic       run_q;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [7:0] fc_q, fc_d;
  phase_e     hph_q, hph_d, vph_q, vph_d;
  logic       line_adv;
  logic       blank_q, blank_d, fs_q, fs_d, vbs_q, vbs_d;
  logic       hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;

  function automatic phase_e phase_step(phase_e ph, logic [9:0] cnt, int unsigned act,
                                        int unsigned fr, int unsigned sy, int unsigned tot);
    phase_e nxt;
    nxt = ph;
    unique case (ph)
      PhActive: if (32'(cnt) == act - 1)           nxt = PhFront;
      PhFront:  if (32'(cnt) == act + fr - 1)      nxt = PhSync;
      PhSync:   if (32'(cnt) == act + fr + sy - 1) nxt = PhBack;
      PhBack:   if (32'(cnt) == tot - 1)           nxt = PhActive;
      default:                                     nxt = PhActive;
    endcase
    return nxt;
  endfunction

  always_comb begin
    hc_d     = hc_q;
    vc_d     = vc_q;
    fc_d     = fc_q;
    hph_d    = hph_q;
    vph_d    = vph_q;
    line_adv = 1'b0;
    if (run_q) begin
      hph_d = phase_step(hph_q, hc_q, H_ACTIVE, H_FRONT, H_SYNC, H_TOTAL);
      if (32'(hc_q) == H_TOTAL - 1) begin
        hc_d     = '0;
        line_adv = 1'b1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
      if (line_adv) begin
        vph_d = phase_step(vph_q, vc_q, V_ACTIVE, V_FRONT, V_SYNC, V_TOTAL);
        if (32'(vc_q) == V_TOTAL - 1) begin
          vc_d = '0;
          fc_d = fc_q + 8'd1;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end
    end
    // Decode from next-state so every registered flag matches the registered hc/vc.
    blank_d  = (32'(hc_d) < H_ACTIVE) && (32'(vc_d) < V_ACTIVE);
    fs_d     = (hc_d == 10'd0) && (vc_d == 10'd0);
    vbs_d    = (hc_d == 10'd0) && (32'(vc_d) == V_ACTIVE);
    hs_raw_d = !((32'(hc_d) >= H_SYNC_BEG) && (32'(hc_d) < H_SYNC_END));
    vs_raw_d = !((32'(vc_d) >= V_SYNC_BEG) && (32'(vc_d) < V_SYNC_END));
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      run_q    <= 1'b0;
      hc_q     <= '0;
      vc_q     <= '0;
      fc_q     <= '0;
      hph_q    <= PhActive;
      vph_q    <= PhActive;
      blank_q  <= 1'b0;
      fs_q     <= 1'b0;
      vbs_q    <= 1'b0;
      hs_raw_q <= 1'b1;
      vs_raw_q <= 1'b1;
    end else begin
      run_q    <= 1'b1;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      fc_q     <= fc_d;
      hph_q    <= hph_d;
      vph_q    <= vph_d;
      blank_q  <= blank_d;
      fs_q     <= fs_d;
      vbs_q    <= vbs_d;
      hs_raw_q <= hs_raw_d;
      vs_raw_q <= vs_raw_d;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_direct
      assign hs = hs_raw_q;
      assign vs = vs_raw_q;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_q, vs_pipe_q;
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_pipe_q <= '1;
          vs_pipe_q <= '1;
        end else begin
          hs_pipe_q <= (hs_pipe_q << 1) | SYNC_DELAY'(hs_raw_q);
          vs_pipe_q <= (vs_pipe_q << 1) | SYNC_DELAY'(vs_raw_q);
        end
      end
      assign hs = hs_pipe_q[SYNC_DELAY-1];
      assign vs = vs_pipe_q[SYNC_DELAY-1];
    end
  endgenerate

  assign DrawX        = hc_q;
  assign DrawY        = vc_q;
  assign blank        = blank_q;
  assign frame_start  = fs_q;
  assign vblank_start = vbs_q;
  assign frame_count  = fc_q;

  // Counters are 10 bits wide.
  params_fit: assert property (@(posedge vga_clk) (H_TOTAL <= 1024) && (V_TOTAL <= 1024));

endmodule
